// File: rtl/cpu_bp_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter encodings,
// the BTB entry layout and the PC index/tag slicing function.
package cpu_bp_pkg;

   localparam int BP_XLEN  = 32;
   localparam int BP_TAG_W = 8;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_t;

   typedef struct packed {
      logic                valid;
      logic [BP_TAG_W-1:0] tag;
      logic [BP_XLEN-1:0]  target;
   } btb_entry_t;

   // Extract pc[lsb +: width]; callers size-cast the result to the field width.
   function automatic logic [63:0] pc_slice(input logic [63:0] pc,
                                            input int unsigned lsb,
                                            input int unsigned width);
      return (pc >> lsb) & ((64'd1 << width) - 64'd1);
   endfunction

   function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
      if (taken) return (c == CTR_ST)  ? CTR_ST  : ctr_t'(c + 2'd1);
      else       return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
   endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 32-bit statistics counter: increments on inc_i, holds at all-ones,
// synchronous clear has priority over increment.
module bp_sat_counter (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inc_i,
   input  logic        clr_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         count_q <= '0;
      else if (clr_i)
         count_q <= '0;
      else if (inc_i && (count_q != 32'hFFFF_FFFF))
         count_q <= count_q + 32'd1;
   end

   assign count_o = count_q;

endmodule

// File: rtl/branch_predictor.sv
// BTB + 2-bit PHT dynamic branch predictor with branch/mispredict statistics.
// Define BP_GSHARE_EN to XOR a global history register into the PHT index.
module branch_predictor
   import cpu_bp_pkg::*;
#(
   parameter int XLEN    = BP_XLEN,
   parameter int ENTRIES = 64,
   parameter int TAG_W   = BP_TAG_W,
   parameter int GHR_W   = 6
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] lookup_pc_i,
   output logic            pred_taken_o,
   output logic [XLEN-1:0] pred_target_o,
   input  logic            upd_valid_i,
   input  logic [XLEN-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [XLEN-1:0] upd_target_i,
   input  logic            upd_pred_taken_i,
   input  logic [XLEN-1:0] upd_pred_target_i,
   output logic            mispredict_o,
   input  logic            stat_clr_i,
   output logic [31:0]     stat_branches_o,
   output logic [31:0]     stat_mispred_o
);

   localparam int IDX_W = $clog2(ENTRIES);

   // The BTB entry layout is fixed by the package, so the widths must agree.
   if (XLEN != BP_XLEN || TAG_W != BP_TAG_W) begin : g_bad_width
      $error("branch_predictor: XLEN/TAG_W must match cpu_bp_pkg");
   end
   if (ENTRIES < 4 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
      $error("branch_predictor: ENTRIES must be a power of two >= 4");
   end
   if (IDX_W + TAG_W + 2 > XLEN || GHR_W > IDX_W) begin : g_bad_fields
      $error("branch_predictor: address fields or GHR_W out of range");
   end

   btb_entry_t btb [ENTRIES];
   ctr_t       pht [ENTRIES];

   logic [IDX_W-1:0] lk_idx, lk_pidx, up_idx, up_pidx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   btb_entry_t       lk_entry;
   logic             lk_hit;

   assign lk_idx = IDX_W'(pc_slice(64'(lookup_pc_i), 2, IDX_W));
   assign lk_tag = TAG_W'(pc_slice(64'(lookup_pc_i), IDX_W + 2, TAG_W));
   assign up_idx = IDX_W'(pc_slice(64'(upd_pc_i), 2, IDX_W));
   assign up_tag = TAG_W'(pc_slice(64'(upd_pc_i), IDX_W + 2, TAG_W));

`ifdef BP_GSHARE_EN
   logic [GHR_W-1:0] ghr;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         ghr <= '0;
      else if (upd_valid_i)
         ghr <= GHR_W'({ghr, upd_taken_i});
   end

   // Lookup and update both hash with the committed history.
   assign lk_pidx = lk_idx ^ IDX_W'(ghr);
   assign up_pidx = up_idx ^ IDX_W'(ghr);
`else
   assign lk_pidx = lk_idx;
   assign up_pidx = up_idx;
`endif

   assign lk_entry      = btb[lk_idx];
   assign lk_hit        = lk_entry.valid && (lk_entry.tag == lk_tag);
   assign pred_taken_o  = lk_hit && pht[lk_pidx][1];
   assign pred_target_o = pred_taken_o ? lk_entry.target : lookup_pc_i + XLEN'(4);

   assign mispredict_o = upd_valid_i &&
                         ((upd_pred_taken_i != upd_taken_i) ||
                          (upd_taken_i && (upd_pred_target_i != upd_target_i)));

   // NOTE: the tables are reset as a whole because valid bits and counters need known start values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb[i] <= '0;
            pht[i] <= CTR_WNT;
         end
      end else if (upd_valid_i) begin
         pht[up_pidx] <= ctr_next(pht[up_pidx], upd_taken_i);
         if (upd_taken_i)
            btb[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target_i};
      end
   end

   bp_sat_counter u_branches (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (upd_valid_i),
      .clr_i   (stat_clr_i),
      .count_o (stat_branches_o)
   );

   bp_sat_counter u_mispred (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (mispredict_o),
      .clr_i   (stat_clr_i),
      .count_o (stat_mispred_o)
   );

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the pipelined RISC-V core. It replaces static "predict not-taken, flush on taken" with a branch target buffer (BTB) and a pattern history table (PHT) of 2-bit saturating counters. It is looked up combinationally in IF and trained by the branch-resolution logic in ID. It also keeps branch and mispredict statistics.

## Interface
- XLEN, 32, address/data width.
- ENTRIES, 64, BTB and PHT depth; power of two, at least 4; IDX_W = log2(ENTRIES).
- TAG_W, 8, BTB tag width; IDX_W + TAG_W + 2 <= XLEN.
- GHR_W, 6, global history length; used only with BP_GSHARE_EN; GHR_W <= IDX_W.
- Ports:
  - clk_i  in  1  clock; all state updates on rising edge.
  - rst_i  in  1  reset, asynchronous, active-high.
  - lookup_pc_i  in  XLEN  PC of the instruction being fetched.
  - pred_taken_o  out  1  predict taken.
  - pred_target_o  out  XLEN  predicted next PC.
  - upd_valid_i  in  1  a conditional branch resolved in ID this cycle.
  - upd_pc_i  in  XLEN  PC of the resolved branch.
  - upd_taken_i  in  1  actual outcome.
  - upd_target_i  in  XLEN  actual taken target.
  - upd_pred_taken_i  in  1  prediction that was made for this branch.
  - upd_pred_target_i  in  XLEN  predicted target for this branch.
  - mispredict_o  out  1  combinational: the resolving branch was mispredicted; drives IF flush.
  - stat_clr_i  in  1  synchronous clear of the statistics counters.
  - stat_branches_o  out  32  resolved-branch count.
  - stat_mispred_o  out  32  mispredict count.

## Operation
- Address fields:
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- BTB entry holds valid, tag and target. PHT entry holds a 2-bit counter.
- PHT index (pidx) is idx, or idx XOR GHR under BP_GSHARE_EN.
- Lookup (combinational):
  - hit = btb.valid && (btb.tag == tag).
  - pred_taken_o = hit && pht[pidx][1].
  - pred_target_o = pred_taken_o ? btb.target : lookup_pc_i + 4, wrapping modulo 2^XLEN.
- mispredict_o = upd_valid_i && ((upd_pred_taken_i != upd_taken_i) || (upd_taken_i && upd_pred_target_i != upd_target_i)).
- Update, on a rising edge with upd_valid_i = 1:
  - PHT[pidx] saturating: taken increments (max 11), not-taken decrements (min 00). Trained on BTB hit and miss alike.
  - BTB, taken: write valid=1, tag and target, overwriting any resident entry (direct-mapped replacement).
  - BTB, not-taken: unchanged; no allocation.
  - Statistics:
    - stat_branches_o increments by 1.
    - stat_mispred_o increments by 1 when mispredict_o is high.
    - Both saturate at 32'hFFFF_FFFF.
- Statistics clear: stat_clr_i = 1 zeroes both counters and takes priority over a same-cycle increment.

## Timing
- Lookup has zero latency. An update is visible to lookup from the cycle after its clock edge.
- Same-cycle lookup and update to the same index: lookup sees the pre-update contents; no bypass.
- Reset values:
  - all BTB valid bits 0;
  - all PHT counters 2'b01 (weakly not-taken);
  - GHR 0;
  - stat counters 0.
- Outputs at reset: pred_taken_o = 0 and pred_target_o = lookup_pc_i + 4.
- rst_i asserted during an update cycle discards that update. Reset overrides everything asynchronously.

## Configuration
- BP_GSHARE_EN defined:
  - GHR_W-bit global history register; on each update it shifts left and upd_taken_i enters at bit 0.
  - pidx = idx XOR zero-extended GHR.
  - Lookup and update both use the current committed GHR.
- BP_GSHARE_EN undefined: no GHR is instantiated, pidx = idx, and GHR_W is ignored.

## Structure
- Shared package cpu_bp_pkg holds:
  - counter encodings CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11;
  - the BTB entry typedef (valid, tag, target);
  - the PC-to-index/tag slicing function.
- One sub-module, bp_sat_counter: a 32-bit saturating counter with increment and sync clear. It is instantiated twice, for the two statistics counters.

## Test plan
- After reset, lookup_pc_i=0x100 -> pred_taken_o=0, pred_target_o=0x104, stat counters 0.
- Update pc=0x100 taken, target 0x40 (pred_taken=0) -> mispredict_o=1. Next cycle lookup 0x100 gives pred_taken_o=1, pred_target_o=0x40, stat_branches_o=1, stat_mispred_o=1.
- Two not-taken updates at 0x100 after the above -> counter 10→01→00, lookup pred_taken_o=0. Three taken updates -> counter saturates at 11; one further not-taken update keeps pred_taken_o=1.
- Aliasing (ENTRIES=64): allocate 0x100, then taken update 0x200 (same idx, different tag) -> lookup 0x100 misses, pred_target_o=0x104.
- stat_clr_i asserted together with a mispredicting update -> both counters read 0 next cycle. Preload stat_mispred_o to 0xFFFF_FFFF, then mispredict -> it stays 0xFFFF_FFFF.
- rst_i pulsed mid-sequence, asynchronous to the clock, during an update -> outputs return to reset values immediately and the update is lost.
- With BP_GSHARE_EN: taken then not-taken updates -> GHR=2'b10 in the low bits, and the PHT index for 0x100 becomes idx XOR 0b10.
